// File: rtl/shifter8_seq_ctrl_if.sv
// Command/result bundle for the 8-bit shifter sequencer.
// The master side issues commands; the slave side is the sequencer.
interface shifter8_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, d_in,
        input  q, busy, done
    );

    modport slave (
        input  start, op, amt, d_in,
        output q, busy, done
    );
endinterface

// File: rtl/shifter8_seq_ctrl.sv
// Sequencing controller for the 8-bit shifter: one bit per clock.
// Define SHIFTER8_ROTATE_EN to make op 11 a rotate-right (else LSR).
module shifter8_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic clk,
    input logic reset,
    shifter8_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shifted;
    logic [AMT_W-1:0] count;
    logic [1:0]       op_r;
    logic             accept;
    logic             step;

    assign accept = (state == IDLE) && bus.start;
    assign step   = (state == SHIFT) && (count != '0);
    assign bus.q  = q_r;

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-bit shift of the current contents for the latched operation.
    always_comb begin
        shifted = q_r;
        unique case (op_r)
            2'b00: shifted = {q_r[WIDTH-2:0], 1'b0};
            2'b01: shifted = {1'b0, q_r[WIDTH-1:1]};
            2'b10: shifted = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
`ifdef SHIFTER8_ROTATE_EN
            2'b11: shifted = {q_r[0], q_r[WIDTH-1:1]};
`else
            2'b11: shifted = {1'b0, q_r[WIDTH-1:1]};
`endif
            default: shifted = q_r;
        endcase
    end

    // Datapath: capture the command on accept, then consume the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r   <= '0;
            count <= '0;
            op_r  <= 2'b00;
        end else if (accept) begin
            q_r   <= bus.d_in;
            count <= bus.amt;
            op_r  <= bus.op;
        end else if (step) begin
            q_r   <= shifted;
            count <= count - 1'b1;
        end
    end
endmodule
